// File: rtl/vproc_fpu_red_seq.sv
// Ordered FP32 vector reduction sequencer for a single FPU lane.
// Walks the active elements of vs2 strictly in order, issuing one
// (accumulator, element) request at a time and folding each result back
// into the accumulator before the next request is issued.
module vproc_fpu_red_seq #(
    parameter int unsigned OP_W   = 64,
    parameter int unsigned ELEM_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 async_rst_ni,

    input  logic                 start_valid_i,
    output logic                 start_ready_o,
    input  logic [ELEM_W-1:0]    start_init_i,
    input  logic [CNT_W-1:0]     start_cnt_i,

    input  logic                 chunk_valid_i,
    output logic                 chunk_ready_o,
    input  logic [OP_W-1:0]      chunk_data_i,
    input  logic [OP_W/32-1:0]   chunk_mask_i,

    output logic                 fpu_req_valid_o,
    input  logic                 fpu_req_ready_i,
    output logic [ELEM_W-1:0]    fpu_op_a_o,
    output logic [ELEM_W-1:0]    fpu_op_b_o,

    input  logic                 fpu_rsp_valid_i,
    output logic                 fpu_rsp_ready_o,
    input  logic [ELEM_W-1:0]    fpu_rsp_data_i,

    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [ELEM_W-1:0]    res_data_o
);

    localparam int unsigned N_ELEM = OP_W / 32;
    localparam int unsigned IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned BUF_W  = N_ELEM * ELEM_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]                         state_q, state_d;
    logic [ELEM_W-1:0]                  acc_q, acc_d;
    logic [CNT_W-1:0]                   rem_q, rem_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [N_ELEM-1:0][ELEM_W-1:0]      buf_q, buf_d;
    logic [N_ELEM-1:0]                  mask_q, mask_d;

    logic [2:0]                         consume_state;
    logic [ELEM_W-1:0]                  cur_elem;

    assign cur_elem = buf_q[idx_q];

    // Where to go once the current element has been consumed (skipped or folded).
    always_comb begin
        consume_state = S_SCAN;
        if (rem_q == CNT_W'(1)) begin
            consume_state = S_DONE;
        end else if (idx_q == IDX_W'(N_ELEM - 1)) begin
            consume_state = S_LOAD;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        mask_d  = mask_q;

        case (state_q)
            S_IDLE: begin
                if (start_valid_i) begin
                    acc_d   = start_init_i;
                    rem_d   = start_cnt_i;
                    state_d = (start_cnt_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (chunk_valid_i) begin
                    buf_d   = BUF_W'(chunk_data_i);
                    mask_d  = chunk_mask_i;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (mask_q[idx_q]) begin
                    state_d = S_ISSUE;
                end else begin
                    rem_d   = rem_q - CNT_W'(1);
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = consume_state;
                end
            end
            S_ISSUE: begin
                if (fpu_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fpu_rsp_valid_i) begin
                    acc_d   = fpu_rsp_data_i;
                    rem_d   = rem_q - CNT_W'(1);
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = consume_state;
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            mask_q  <= mask_d;
        end
    end

    // Handshake outputs decode the state register only; no input-to-output paths.
    assign start_ready_o   = (state_q == S_IDLE);
    assign chunk_ready_o   = (state_q == S_LOAD);
    assign fpu_req_valid_o = (state_q == S_ISSUE);
    assign fpu_rsp_ready_o = (state_q == S_WAIT);
    assign res_valid_o     = (state_q == S_DONE);
    assign fpu_op_a_o      = acc_q;
    assign fpu_op_b_o      = cur_elem;
    assign res_data_o      = acc_q;

endmodule

// File: tb/tb_vproc_fpu_red_seq.sv
// Directed bench for vproc_fpu_red_seq with an FP32-adding FPU model and
// queue-based expectations for FPU requests and final results.
module tb_vproc_fpu_red_seq;

    logic        clk_i = 1'b0;
    logic        async_rst_ni;
    logic        start_valid_i;
    logic        start_ready_o;
    logic [31:0] start_init_i;
    logic [7:0]  start_cnt_i;
    logic        chunk_valid_i;
    logic        chunk_ready_o;
    logic [63:0] chunk_data_i;
    logic [1:0]  chunk_mask_i;
    logic        fpu_req_valid_o;
    logic        fpu_req_ready_i;
    logic [31:0] fpu_op_a_o;
    logic [31:0] fpu_op_b_o;
    logic        fpu_rsp_valid_i;
    logic        fpu_rsp_ready_o;
    logic [31:0] fpu_rsp_data_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_data_o;

    vproc_fpu_red_seq #(.OP_W(64), .ELEM_W(32), .CNT_W(8)) dut (
        .clk_i           (clk_i),
        .async_rst_ni    (async_rst_ni),
        .start_valid_i   (start_valid_i),
        .start_ready_o   (start_ready_o),
        .start_init_i    (start_init_i),
        .start_cnt_i     (start_cnt_i),
        .chunk_valid_i   (chunk_valid_i),
        .chunk_ready_o   (chunk_ready_o),
        .chunk_data_i    (chunk_data_i),
        .chunk_mask_i    (chunk_mask_i),
        .fpu_req_valid_o (fpu_req_valid_o),
        .fpu_req_ready_i (fpu_req_ready_i),
        .fpu_op_a_o      (fpu_op_a_o),
        .fpu_op_b_o      (fpu_op_b_o),
        .fpu_rsp_valid_i (fpu_rsp_valid_i),
        .fpu_rsp_ready_o (fpu_rsp_ready_o),
        .fpu_rsp_data_i  (fpu_rsp_data_i),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .res_data_o      (res_data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_count = 0;
    int chunk_rdy_cycles = 0;
    int t_start = 0;

    logic [63:0] exp_req[$];
    logic [31:0] exp_res[$];
    logic [31:0] acc_m;
    int          rem_m;

    logic        pending = 1'b0;
    logic [31:0] pend_data;

    always @(posedge clk_i) cyc++;
    always @(negedge clk_i) if (chunk_ready_o) chunk_rdy_cycles++;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        e = int'(b[30:23]) - 127;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        if (e >= 0) for (int i = 0; i < e; i++) m = m * 2.0;
        else        for (int i = 0; i < -e; i++) m = m / 2.0;
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic        s;
        int          e;
        real         m;
        logic [22:0] f;
        if (r == 0.0) return 32'd0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, 8'(e + 127), f};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timeout waiting for DUT", tag);
    endtask

    // FPU lane model: latency 1, checks each accepted request against the scoreboard.
    always begin
        @(negedge clk_i);
        #2;
        if (!async_rst_ni) begin
            pending         = 1'b0;
            fpu_rsp_valid_i = 1'b0;
        end else begin
            if (fpu_rsp_valid_i) fpu_rsp_valid_i = 1'b0;
            if (pending) begin
                fpu_rsp_valid_i = 1'b1;
                fpu_rsp_data_i  = pend_data;
                pending         = 1'b0;
            end
            if (fpu_req_valid_o && fpu_req_ready_i) begin
                req_count++;
                if (exp_req.size() == 0) begin
                    chk("unexpected_fpu_req", {fpu_op_a_o, fpu_op_b_o}, 64'hxxxx_xxxx_xxxx_xxxx);
                end else begin
                    chk("fpu_req_ops", {fpu_op_a_o, fpu_op_b_o}, exp_req.pop_front());
                end
                pend_data = fadd(fpu_op_a_o, fpu_op_b_o);
                pending   = 1'b1;
            end
        end
    end

    task automatic expect_elem(input logic active, input logic [31:0] e);
        if (rem_m == 0) return;
        if (active) begin
            exp_req.push_back({acc_m, e});
            acc_m = fadd(acc_m, e);
        end
        rem_m--;
        if (rem_m == 0) exp_res.push_back(acc_m);
    endtask

    task automatic do_start(input logic [31:0] init, input logic [7:0] cnt);
        int n = 0;
        start_valid_i = 1'b1;
        start_init_i  = init;
        start_cnt_i   = cnt;
        acc_m = init;
        rem_m = int'(cnt);
        if (cnt == 8'd0) exp_res.push_back(init);
        while (!start_ready_o && n < 200) begin @(negedge clk_i); n++; end
        if (n >= 200) timeout_fail("start_handshake");
        t_start = cyc;
        @(negedge clk_i);
        start_valid_i = 1'b0;
    endtask

    task automatic send_chunk(input logic [31:0] e1, input logic [31:0] e0, input logic [1:0] m);
        int n = 0;
        expect_elem(m[0], e0);
        expect_elem(m[1], e1);
        while (!chunk_ready_o && n < 200) begin @(negedge clk_i); n++; end
        if (n >= 200) timeout_fail("chunk_handshake");
        chunk_valid_i = 1'b1;
        chunk_data_i  = {e1, e0};
        chunk_mask_i  = m;
        @(negedge clk_i);
        chunk_valid_i = 1'b0;
    endtask

    task automatic get_result(input string tag, input int exp_lat, input int hold);
        int n = 0;
        logic [31:0] er;
        while (!res_valid_o && n < 200) begin @(negedge clk_i); n++; end
        if (n >= 200) begin
            timeout_fail(tag);
            return;
        end
        chk({tag, "_latency"}, 64'(cyc - t_start), 64'(exp_lat));
        er = (exp_res.size() != 0) ? exp_res.pop_front() : 32'hxxxx_xxxx;
        chk({tag, "_res_data"}, 64'(res_data_o), 64'(er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk({tag, "_res_hold"}, {31'd0, res_valid_o, res_data_o}, {31'd0, 1'b1, er});
        end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        chk({tag, "_req_queue_empty"}, 64'(exp_req.size()), 64'd0);
    endtask

    initial begin
        int rc0;
        int cr0;
        int n;
        async_rst_ni    = 1'b0;
        start_valid_i   = 1'b0;
        start_init_i    = '0;
        start_cnt_i     = '0;
        chunk_valid_i   = 1'b0;
        chunk_data_i    = '0;
        chunk_mask_i    = '0;
        fpu_req_ready_i = 1'b1;
        fpu_rsp_valid_i = 1'b0;
        fpu_rsp_data_i  = '0;
        res_ready_i     = 1'b0;
        repeat (2) @(negedge clk_i);

        // Reset state
        chk("rst_start_ready", 64'(start_ready_o), 64'd1);
        chk("rst_valids", {60'd0, chunk_ready_o, fpu_req_valid_o, fpu_rsp_ready_o, res_valid_o}, 64'd0);
        chk("rst_res_data", 64'(res_data_o), 64'd0);
        async_rst_ni = 1'b1;
        @(negedge clk_i);

        // Reset asserted while waiting for an FPU result
        do_start(32'h3F800000, 8'd2);
        send_chunk(32'h40400000, 32'h40000000, 2'b11);
        n = 0;
        while (!fpu_rsp_ready_o && n < 200) begin @(negedge clk_i); n++; end
        if (n >= 200) timeout_fail("reach_wait");
        async_rst_ni = 1'b0;
        #1;
        chk("midrst_valids", {60'd0, chunk_ready_o, fpu_req_valid_o, fpu_rsp_ready_o, res_valid_o}, 64'd0);
        chk("midrst_start_ready", 64'(start_ready_o), 64'd1);
        exp_req.delete();
        exp_res.delete();
        repeat (2) @(negedge clk_i);
        async_rst_ni = 1'b1;
        @(negedge clk_i);
        chk("postrst_start_ready", 64'(start_ready_o), 64'd1);

        // Basic ordered sum: 1 + 2 + 3 = 6
        rc0 = req_count; cr0 = chunk_rdy_cycles;
        do_start(32'h3F800000, 8'd2);
        send_chunk(32'h40400000, 32'h40000000, 2'b11);
        get_result("basic", 8, 0);
        chk("basic_res_const", 64'(res_data_o), 64'h40C00000);
        chk("basic_req_count", 64'(req_count - rc0), 64'd2);
        chk("basic_chunk_loads", 64'(chunk_rdy_cycles - cr0), 64'd1);

        // Masked skip: elements 1 and 2 only, 1 + 2 + 4 = 7
        rc0 = req_count;
        do_start(32'h3F800000, 8'd4);
        send_chunk(32'h40000000, 32'h41000000, 2'b10);
        send_chunk(32'h41200000, 32'h40800000, 2'b01);
        get_result("masked", 11, 0);
        chk("masked_res_const", 64'(res_data_o), 64'h40E00000);
        chk("masked_req_count", 64'(req_count - rc0), 64'd2);

        // Zero count: no chunk, no FPU traffic, result next cycle
        rc0 = req_count; cr0 = chunk_rdy_cycles;
        do_start(32'hC0A00000, 8'd0);
        get_result("zero", 1, 0);
        chk("zero_req_count", 64'(req_count - rc0), 64'd0);
        chk("zero_chunk_ready", 64'(chunk_rdy_cycles - cr0), 64'd0);

        // Odd count spanning a partial second chunk: 0 + 1 + 2 + 4 = 7
        rc0 = req_count; cr0 = chunk_rdy_cycles;
        do_start(32'h00000000, 8'd3);
        send_chunk(32'h40000000, 32'h3F800000, 2'b11);
        send_chunk(32'h41000000, 32'h40800000, 2'b11);
        get_result("odd", 12, 0);
        repeat (4) @(negedge clk_i);
        chk("odd_res_const", 64'(res_data_o), 64'h40E00000);
        chk("odd_req_count", 64'(req_count - rc0), 64'd3);
        chk("odd_chunk_loads", 64'(chunk_rdy_cycles - cr0), 64'd2);

        // Backpressure on FPU request and on result
        rc0 = req_count;
        fpu_req_ready_i = 1'b0;
        do_start(32'h3F800000, 8'd1);
        send_chunk(32'h40A00000, 32'h40000000, 2'b11);
        n = 0;
        while (!fpu_req_valid_o && n < 200) begin @(negedge clk_i); n++; end
        if (n >= 200) timeout_fail("bp_req_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_req_hold", {31'd0, fpu_req_valid_o, fpu_op_a_o}, {31'd0, 1'b1, 32'h3F800000});
            chk("bp_op_b_hold", 64'(fpu_op_b_o), 64'h40000000);
        end
        fpu_req_ready_i = 1'b1;
        get_result("bp", 10, 3);
        chk("bp_req_count", 64'(req_count - rc0), 64'd1);

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
